// File: rtl/aes_sched_pkg.sv
// +------------------------------------------------------------------+
// | aes_sched_pkg : shared types and constants for aes_round_sched   |
// | Revision      : 1.0                                              |
// +------------------------------------------------------------------+
`default_nettype none

package aes_sched_pkg;

    localparam int AES256_NUM_ROUNDS = 14;
    localparam int RK_W              = 128;
    localparam int KEY_W             = 256;
    localparam int RIDX_W            = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYGEN = 2'd1,
        ISSUE  = 2'd2,
        WAIT   = 2'd3
    } sched_state_e;

endpackage : aes_sched_pkg

`default_nettype wire

// File: rtl/aes_round_sched_store.sv
// +------------------------------------------------------------------+
// | round_key_store : round-key register file, 1 sync write port and |
// |                   1 combinational read port                      |
// | Revision        : 1.0                                            |
// +------------------------------------------------------------------+
`default_nettype none

module round_key_store
    import aes_sched_pkg::*;
#(
    parameter int DEPTH = AES256_NUM_ROUNDS + 1
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [RIDX_W-1:0] waddr_i,
    input  logic [RK_W-1:0]   wdata_i,
    input  logic [RIDX_W-1:0] raddr_i,
    output logic [RK_W-1:0]   rdata_o
);

    // Contents are don't-care after reset, so the array carries no reset.
    logic [RK_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : round_key_store

`default_nettype wire

// File: rtl/aes_round_sched.sv
// +------------------------------------------------------------------+
// | aes_round_sched : AES-256 round sequencer with cached key store. |
// | Option macro AES_SCHED_OVERLAP_EN overlaps rounds with keygen.   |
// | Revision        : 1.0                                            |
// +------------------------------------------------------------------+
`default_nettype none

module aes_round_sched
    import aes_sched_pkg::*;
#(
    parameter int NUM_ROUNDS = AES256_NUM_ROUNDS,
    parameter int KG_TIMEOUT = 96
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              key_new,
    input  logic [KEY_W-1:0]  init_key_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [KEY_W-1:0]  kg_init_key,
    output logic              kg_advance,
    input  logic [RK_W-1:0]   kg_round_key,
    input  logic              kg_round_key_valid,
    output logic              rd_start,
    output logic [RIDX_W-1:0] rd_round_idx,
    output logic [RK_W-1:0]   rd_round_key,
    output logic              rd_final,
    input  logic              rd_done
);

    localparam int KCNT_W = RIDX_W + 1;
    localparam int TCNT_W = $clog2(KG_TIMEOUT + 1);

    localparam logic [RIDX_W-1:0] LAST_RND  = RIDX_W'(NUM_ROUNDS);
    localparam logic [KCNT_W-1:0] NUM_KEYS  = KCNT_W'(NUM_ROUNDS + 1);
    localparam logic [KCNT_W-1:0] LAST_KIDX = KCNT_W'(NUM_ROUNDS);
    localparam logic [TCNT_W-1:0] TO_LAST   = TCNT_W'(KG_TIMEOUT - 1);

    sched_state_e      state_q, state_d;
    logic              cached_q, cached_d;
    logic              coll_q, coll_d;
    logic [KCNT_W-1:0] kcnt_q, kcnt_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [RIDX_W-1:0] r_q, r_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic              adv_q, adv_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              key_we;
    logic              key_last;
    logic              timeout;
    logic              rd_active;
    logic [RK_W-1:0]   store_rdata;

    // Collection runs on its own flag so the overlap build can sequence
    // rounds while keys are still arriving.
    assign key_we   = coll_q && kg_round_key_valid && (kcnt_q < NUM_KEYS);
    assign key_last = key_we && (kcnt_q == LAST_KIDX);
    assign timeout  = coll_q && !key_last && (tcnt_q == TO_LAST);

`ifdef AES_SCHED_OVERLAP_EN
    logic keys_ready;
    logic next_ready;
    assign keys_ready = kcnt_q > {1'b0, r_q};
    assign next_ready = kcnt_q > ({1'b0, r_q} + 1'b1);
`endif

    round_key_store #(
        .DEPTH (NUM_ROUNDS + 1)
    ) u_store (
        .clk     (clk),
        .we_i    (key_we),
        .waddr_i (kcnt_q[RIDX_W-1:0]),
        .wdata_i (kg_round_key),
        .raddr_i (r_q),
        .rdata_o (store_rdata)
    );

    always_comb begin
        state_d  = state_q;
        cached_d = cached_q;
        coll_d   = coll_q;
        kcnt_d   = kcnt_q;
        tcnt_d   = tcnt_q;
        r_d      = r_q;
        key_d    = key_q;
        adv_d    = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;

        if (coll_q) begin
            tcnt_d = tcnt_q + 1'b1;
            if (key_we) begin
                kcnt_d = kcnt_q + 1'b1;
            end
            if (key_last) begin
                coll_d   = 1'b0;
                cached_d = 1'b1;
            end
        end

        if (timeout) begin
            coll_d  = 1'b0;
            state_d = IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        r_d = '0;
                        if (key_new || !cached_q) begin
                            key_d    = init_key_in;
                            cached_d = 1'b0;
                            coll_d   = 1'b1;
                            kcnt_d   = '0;
                            tcnt_d   = '0;
                            adv_d    = 1'b1;
                            state_d  = KEYGEN;
                        end else begin
                            state_d = ISSUE;
                        end
                    end
                end
                KEYGEN: begin
`ifdef AES_SCHED_OVERLAP_EN
                    if (keys_ready) begin
                        state_d = ISSUE;
                    end
`else
                    if (key_last) begin
                        state_d = ISSUE;
                    end
`endif
                end
                ISSUE: begin
                    state_d = WAIT;
                end
                WAIT: begin
                    if (rd_done) begin
                        if (r_q == LAST_RND) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            r_d = r_q + 1'b1;
`ifdef AES_SCHED_OVERLAP_EN
                            // Park in KEYGEN until the next round's key lands.
                            state_d = next_ready ? ISSUE : KEYGEN;
`else
                            state_d = ISSUE;
`endif
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cached_q <= 1'b0;
            coll_q   <= 1'b0;
            kcnt_q   <= '0;
            tcnt_q   <= '0;
            r_q      <= '0;
            key_q    <= '0;
            adv_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cached_q <= cached_d;
            coll_q   <= coll_d;
            kcnt_q   <= kcnt_d;
            tcnt_q   <= tcnt_d;
            r_q      <= r_d;
            key_q    <= key_d;
            adv_q    <= adv_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Round outputs are masked outside ISSUE/WAIT so idle and reset read zero.
    assign rd_active    = (state_q == ISSUE) || (state_q == WAIT);
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign err          = err_q;
    assign kg_init_key  = key_q;
    assign kg_advance   = adv_q;
    assign rd_start     = (state_q == ISSUE);
    assign rd_round_idx = rd_active ? r_q : '0;
    assign rd_round_key = rd_active ? store_rdata : '0;
    assign rd_final     = rd_active && (r_q == LAST_RND);

endmodule : aes_round_sched

`default_nettype wire

// File: tb/tb_aes_round_sched.sv
// +------------------------------------------------------------------+
// | tb_aes_round_sched : table-driven, scoreboarded bench for        |
// | aes_round_sched (honours AES_SCHED_OVERLAP_EN)                   |
// | Revision           : 1.0                                         |
// +------------------------------------------------------------------+
`default_nettype none

module tb_aes_round_sched;

    localparam int NR = 14;
`ifdef AES_SCHED_OVERLAP_EN
    localparam int COLD_LAT = 6;
    localparam int COLD_DLAT = 66;
    localparam int TO_RS = 10;
    localparam int TO_LAT = 6;
`else
    localparam int COLD_LAT = 61;
    localparam int COLD_DLAT = 121;
    localparam int TO_RS = 0;
    localparam int TO_LAT = -1;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         key_new = 1'b0;
    logic [255:0] init_key_in = '0;
    logic         busy, done, err, kg_advance, rd_start, rd_final;
    logic [255:0] kg_init_key;
    logic [127:0] kg_round_key = '0;
    logic         kg_round_key_valid = 1'b0;
    logic [3:0]   rd_round_idx;
    logic [127:0] rd_round_key;
    logic         rd_done = 1'b0;

    aes_round_sched #(.NUM_ROUNDS(NR), .KG_TIMEOUT(96)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_new(key_new),
        .init_key_in(init_key_in), .busy(busy), .done(done), .err(err),
        .kg_init_key(kg_init_key), .kg_advance(kg_advance),
        .kg_round_key(kg_round_key), .kg_round_key_valid(kg_round_key_valid),
        .rd_start(rd_start), .rd_round_idx(rd_round_idx),
        .rd_round_key(rd_round_key), .rd_final(rd_final), .rd_done(rd_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] key;
    } exp_t;

    typedef struct {
        logic         kn;
        logic [255:0] key;
        int           emit;
        int           exp_adv;
        int           exp_rs;
        int           exp_err;
        int           exp_lat;
        int           exp_dlat;
    } vec_t;

    exp_t         sb_q[$];
    exp_t         last_e;
    int           n_checks = 0, n_pass = 0;
    int           cyc = 0, kg_emit = 15;
    int           n_adv, n_rs, n_done, n_err, n_valid;
    int           first_rs_cyc, valid15_cyc, done_cyc, err_cyc;
    logic         model_cached = 1'b0;
    logic [255:0] model_key = '0;
    logic [127:0] model_keys [NR+1];

    function automatic logic [127:0] model_rk(input logic [255:0] k, input int i);
        logic [31:0] m;
        m = 32'(i + 1) * 32'h9E37_79B9;
        return k[255:128] ^ k[127:0] ^ {m, ~m, m ^ 32'hA5A5_A5A5, m[15:0], m[31:16]};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic clr_stats();
        n_adv = 0; n_rs = 0; n_done = 0; n_err = 0; n_valid = 0;
        first_rs_cyc = -1; valid15_cyc = -1; done_cyc = -1; err_cyc = -1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Behavioural key generator: one valid every 4 cycles after kg_advance.
    initial forever begin
        logic [255:0] k;
        @(negedge clk);
        if (rst_n && kg_advance) begin
            k = kg_init_key;
            for (int i = 0; i < kg_emit; i++) begin
                repeat (3) @(posedge clk);
                #1;
                if (!rst_n) break;
                kg_round_key = model_rk(k, i);
                kg_round_key_valid = 1'b1;
                @(posedge clk);
                #1;
                kg_round_key_valid = 1'b0;
            end
        end
    end

    // Behavioural datapath: rd_done three cycles after each rd_start.
    initial forever begin
        @(negedge clk);
        if (rst_n && rd_start) begin
            repeat (3) @(posedge clk);
            #1;
            rd_done = 1'b1;
            @(posedge clk);
            #1;
            rd_done = 1'b0;
        end
    end

    // Monitor and scoreboard consumer, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (kg_advance) n_adv++;
            if (kg_round_key_valid) begin
                n_valid++;
                if (n_valid == NR + 1) valid15_cyc = cyc;
            end
            if (rd_start) begin
                n_rs++;
                if (first_rs_cyc < 0) first_rs_cyc = cyc;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL rd_start_unexpected: got rd_start idx %0d, expected none", rd_round_idx);
                end else begin
                    last_e = sb_q.pop_front();
                    chk("rd_idx", 256'(rd_round_idx), 256'(last_e.idx));
                    chk("rd_key", 256'(rd_round_key), 256'(last_e.key));
                    chk("rd_final", 256'(rd_final), 256'(last_e.idx == 4'(NR)));
                end
            end else if (rd_done && busy) begin
                chk("rd_key_hold", 256'(rd_round_key), 256'(last_e.key));
                chk("rd_idx_hold", 256'(rd_round_idx), 256'(last_e.idx));
            end
            if (done) begin n_done++; done_cyc = cyc; end
            if (err) begin n_err++; err_cyc = cyc; end
        end
    end

    task automatic run_op(input logic kn, input logic [255:0] key, input int emit, output int s_cyc);
        logic regen;
        clr_stats();
        sb_q.delete();
        kg_emit = emit;
        regen = kn || !model_cached;
        if (regen) begin
            model_key = key;
            for (int i = 0; i <= NR; i++) model_keys[i] = model_rk(key, i);
        end
        for (int i = 0; i <= NR; i++) sb_q.push_back({4'(i), model_keys[i]});
        @(posedge clk);
        #1;
        start = 1'b1; key_new = kn; init_key_in = key; s_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0; key_new = 1'b0;
        chk("busy_after_start", 256'(busy), 256'(1));
    endtask

    task automatic wait_done(input int budget);
        int t;
        t = 0;
        while (n_done == 0 && t < budget) begin
            @(posedge clk);
            t++;
        end
        if (n_done == 0) begin
            n_checks++;
            $display("FAIL done_wait: no done within %0d cycles, expected one", budget);
        end
        repeat (8) @(posedge clk);
        #1;
        chk("busy_after_done", 256'(busy), 256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[4];
        int   s;
        logic [255:0] k0, k1, k2, k3;
        k0 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        k1 = 256'hdeadbeef_0badf00d_12345678_9abcdef0_cafebabe_55aa55aa_0f0f0f0f_f0f0f0f0;
        k2 = 256'h13579bdf_2468ace0_fedcba98_76543210_a5a5a5a5_5a5a5a5a_11223344_55667788;
        k3 = 256'h0123_4567_89ab_cdef_0011_2233_4455_6677_8899_aabb_ccdd_eeff_f00f_e11e_d22d_c33c;

        //          kn    key emit adv rs     err lat       dlat
        vecs[0] = '{1'b1, k0, 15,  1,  15,    0,  COLD_LAT, COLD_DLAT};
        vecs[1] = '{1'b0, k1, 15,  0,  15,    0,  1,        61};
        vecs[2] = '{1'b1, k1, 10,  1,  TO_RS, 1,  TO_LAT,   97};
        vecs[3] = '{1'b0, k2, 15,  1,  15,    0,  COLD_LAT, COLD_DLAT};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 256'({busy, done, err, kg_advance, rd_start, rd_final, rd_round_idx}), 256'(0));
        chk("reset_rd_key", 256'(rd_round_key), 256'(0));
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int v = 0; v < 4; v++) begin
            run_op(vecs[v].kn, vecs[v].key, vecs[v].emit, s);
            wait_done(400);
            chk($sformatf("v%0d_kg_advance", v), 256'(n_adv), 256'(vecs[v].exp_adv));
            chk($sformatf("v%0d_rd_starts", v), 256'(n_rs), 256'(vecs[v].exp_rs));
            chk($sformatf("v%0d_done_count", v), 256'(n_done), 256'(1));
            chk($sformatf("v%0d_err_count", v), 256'(n_err), 256'(vecs[v].exp_err));
            chk($sformatf("v%0d_done_latency", v), 256'(done_cyc - s), 256'(vecs[v].exp_dlat));
            chk($sformatf("v%0d_kg_init_key", v), kg_init_key, model_key);
            if (vecs[v].exp_err != 0)
                chk($sformatf("v%0d_err_with_done", v), 256'(err_cyc), 256'(done_cyc));
            if (vecs[v].exp_lat >= 0)
                chk($sformatf("v%0d_first_rd_latency", v), 256'(first_rs_cyc - s), 256'(vecs[v].exp_lat));
            if (vecs[v].exp_adv != 0 && vecs[v].exp_err == 0) begin
`ifdef AES_SCHED_OVERLAP_EN
                chk($sformatf("v%0d_overlap_early", v), 256'(first_rs_cyc < valid15_cyc), 256'(1));
`else
                chk($sformatf("v%0d_serial_after_keys", v), 256'(first_rs_cyc > valid15_cyc), 256'(1));
`endif
            end
            model_cached = (vecs[v].exp_err == 0);
        end

        // Start pulsed during WAIT of round 5 must be ignored.
        run_op(1'b0, k3, 15, s);
        for (int t = 0; t < 200 && n_rs < 6; t++) @(posedge clk);
        #1;
        start = 1'b1; key_new = 1'b1; init_key_in = k3;
        @(posedge clk);
        #1;
        start = 1'b0; key_new = 1'b0;
        wait_done(400);
        chk("busy_ignore_adv", 256'(n_adv), 256'(0));
        chk("busy_ignore_done", 256'(n_done), 256'(1));
        chk("busy_ignore_rs", 256'(n_rs), 256'(15));
        chk("busy_ignore_dlat", 256'(done_cyc - s), 256'(61));

        // Reset asserted during WAIT of round 7.
        run_op(1'b0, k3, 15, s);
        for (int t = 0; t < 200 && n_rs < 8; t++) @(posedge clk);
        #1;
        chk("pre_reset_round", 256'(rd_round_idx), 256'(7));
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", 256'({busy, done, err, kg_advance, rd_start, rd_final, rd_round_idx}), 256'(0));
        chk("midrst_rd_key", 256'(rd_round_key), 256'(0));
        chk("midrst_kg_key", kg_init_key, 256'(0));
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_cached = 1'b0;
        repeat (2) @(posedge clk);
        run_op(1'b0, k3, 15, s);
        wait_done(400);
        chk("post_reset_adv", 256'(n_adv), 256'(1));
        chk("post_reset_rs", 256'(n_rs), 256'(15));
        chk("post_reset_err", 256'(n_err), 256'(0));
        chk("post_reset_dlat", 256'(done_cyc - s), 256'(COLD_DLAT));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_aes_round_sched

`default_nettype wire

// File: doc/aes_round_sched.md
Name: aes_round_sched

Overview:
- Sequences one AES-256 block operation.
- On a host start, it triggers the round-key generator, captures every emitted round key into a local store, then issues rounds 0..NUM_ROUNDS to the round datapath one at a time over a start/done handshake.
- Sits between the host/top-level FSM, the round-key generator and the round datapath.
- Keeps the expanded keys cached so later blocks under the same key skip regeneration.

Parameters:
- NUM_ROUNDS, 14: last round index; the store holds NUM_ROUNDS+1 keys.
- KG_TIMEOUT, 96: maximum cycles in KEYGEN before abort.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  host request, sampled only in IDLE
- key_new  in  1  with start: 1 = regenerate keys from init_key_in
- init_key_in  in  256  host cipher key, captured on accepted start
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the operation ends
- err  out  1  one-cycle pulse with done on keygen timeout
- kg_init_key  out  256  latched key to generator
- kg_advance  out  1  one-cycle trigger to generator
- kg_round_key  in  128  generator round key
- kg_round_key_valid  in  1  qualifies kg_round_key
- rd_start  out  1  one-cycle pulse: begin round rd_round_idx
- rd_round_idx  out  4  current round index
- rd_round_key  out  128  key for current round; stable until rd_done
- rd_final  out  1  high while rd_round_idx == NUM_ROUNDS
- rd_done  in  1  datapath round complete

Behaviour:
- Reset: all outputs 0; state IDLE; key store contents don't-care; cached=0; key counter and round counter 0.
- IDLE, start=1:
  - If key_new=1 or cached=0: latch init_key_in into kg_init_key, clear cached, go to KEYGEN.
  - Otherwise go to ISSUE with r=0.
  - start while busy is ignored; it is not queued.
- KEYGEN:
  - kg_advance is high exactly on the first cycle in KEYGEN.
  - Each kg_round_key_valid writes kg_round_key to store[kcnt] and increments kcnt.
  - When kcnt reaches NUM_ROUNDS+1: set cached=1 and go to ISSUE with r=0.
  - Valid pulses arriving outside KEYGEN are dropped.
- Timeout: a cycle counter runs from KEYGEN entry. If it reaches KG_TIMEOUT before all keys are stored: pulse err and done together, keep cached=0, go to IDLE.
- ISSUE (one cycle):
  - Pulse rd_start.
  - Drive rd_round_idx=r, rd_round_key=store[r], rd_final=(r==NUM_ROUNDS).
  - Go to WAIT.
- WAIT:
  - Hold rd_round_idx, rd_round_key and rd_final.
  - On rd_done with r<NUM_ROUNDS: r++ and go to ISSUE.
  - On rd_done with r==NUM_ROUNDS: pulse done and go to IDLE.
  - rd_done in any other state is ignored.
- Latency:
  - Cached path: rd_start for round 0 occurs 1 cycle after start is accepted.
  - Each round adds one cycle of overhead after rd_done.
- Store width and indexing: 128 bits per entry, indices 0..NUM_ROUNDS; kcnt and r saturate there.
- Reset mid-operation: everything returns to reset values and cached=0; the next start must regenerate keys.

Optional Feature:
- Macro: AES_SCHED_OVERLAP_EN.
- Defined: ISSUE for round r is allowed as soon as kcnt > r. Rounds overlap key collection, with KEYGEN and round sequencing running concurrently. Timeout still aborts both; on abort, rd_start stops and err/done pulse. busy stays high until both collection and the final round finish.
- Undefined: strictly serial; no rd_start until all NUM_ROUNDS+1 keys are stored.

Decomposition:
- Package aes_sched_pkg:
  - State enum {IDLE, KEYGEN, ISSUE, WAIT}.
  - AES256_NUM_ROUNDS=14, RK_W=128, KEY_W=256, RIDX_W=4.
- One sub-module: round_key_store, a (NUM_ROUNDS+1)x128 register file with 1 synchronous write port and 1 combinational read port.

Test Plan:
- Cold start:
  - Stimulus: key 000102..1e1f, key_new=1; behavioural keygen emits 15 valids at 4-cycle spacing; datapath returns rd_done 3 cycles after each rd_start.
  - Required: kg_advance one pulse; 15 rd_start pulses with idx 0..14; rd_final only at 14; rd_round_key equals keygen outputs in order; single done, err=0.
- Cached reuse:
  - Stimulus: second start with key_new=0.
  - Required: no kg_advance; round-0 rd_start 1 cycle after start; same 15 keys.
- Timeout:
  - Stimulus: keygen emits only 10 valids.
  - Required: err and done pulse together at cycle 96 after KEYGEN entry; no rd_start (serial build); the next start with key_new=0 still regenerates.
- Busy ignore:
  - Stimulus: start pulsed during WAIT of round 5.
  - Required: no effect; exactly one done.
- Reset mid-round:
  - Stimulus: rst_n low during WAIT of round 7.
  - Required: all outputs 0 immediately; the next start with key_new=0 triggers kg_advance.
- Overlap build:
  - Stimulus: cold start as in the first scenario.
  - Required: round-0 rd_start occurs before the 15th kg_round_key_valid; key and index ordering identical to the serial build.
